// File: rtl/mc8123_key_loader.sv
// Captures the 8 KB MC8123 key from the ioctl download stream and serves it over a registered read port.
// Read latency is one cycle, and writes have no backpressure.
module mc8123_key_loader #(
    parameter logic [7:0]  KEY_INDEX = 8'd0,
    parameter logic [24:0] KEY_BASE  = 25'h0C0000,
    parameter int          KEY_BYTES = 8192
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [12:0] key_a,
    output logic [7:0]  key_d,
    output logic        key_valid,
    output logic        load_error,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;

    localparam logic [25:0] KEY_END  = {1'b0, KEY_BASE} + 26'(KEY_BYTES);
    localparam logic [13:0] CNT_FULL = 14'(KEY_BYTES);
    localparam logic [13:0] CNT_SAT  = CNT_FULL + 14'd1;

    state_t      state;
    logic        dl_q;
    logic [13:0] cnt;
    logic        dl_rise;
    logic        dl_fall;
    logic        in_win;
    logic        ram_we;
    logic [12:0] ram_waddr;

    logic [7:0]  ram [0:KEY_BYTES-1];

    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;
    assign in_win  = ioctl_wr && (ioctl_addr >= KEY_BASE) && ({1'b0, ioctl_addr} < KEY_END);
    assign ram_we  = in_win && (state == LOAD);
    // Low 13 bits of the subtraction only depend on the low 13 bits of the operands.
    assign ram_waddr = ioctl_addr[12:0] - KEY_BASE[12:0];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_waddr] <= ioctl_dout;
        end
    end

    // Non-blocking read alongside the write gives read-first behaviour on a collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_d <= 8'h00;
        end else begin
            key_d <= ram[key_a];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            cnt        <= 14'd0;
            key_valid  <= 1'b0;
            load_error <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            case (state)
                IDLE: begin
                    if (dl_rise && (ioctl_index == KEY_INDEX)) begin
                        state      <= LOAD;
                        key_valid  <= 1'b0;
                        load_error <= 1'b0;
                        cnt        <= 14'd0;
                        busy       <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_win && (cnt != CNT_SAT)) begin
                        cnt <= cnt + 14'd1;
                    end
                    if (dl_fall) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (cnt == CNT_FULL) begin
                        key_valid  <= 1'b1;
                        load_error <= 1'b0;
                    end else if (cnt == 14'd0) begin
                        key_valid  <= 1'b0;
                        load_error <= 1'b0;
                    end else begin
                        key_valid  <= 1'b0;
                        load_error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc8123_key_loader.sv
// Bench for mc8123_key_loader: reference key model plus a queue of expected read data.
module tb_mc8123_key_loader;

    localparam logic [7:0]  KEY_INDEX = 8'd0;
    localparam logic [24:0] KEY_BASE  = 25'h0C0000;
    localparam int          KEY_BYTES = 8192;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [24:0] ioctl_addr = 25'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic [12:0] key_a = 13'd0;
    logic [7:0]  key_d;
    logic        key_valid;
    logic        load_error;
    logic        busy;

    int passed = 0;
    int total  = 0;

    logic [7:0] model [0:KEY_BYTES-1];
    logic [7:0] exp_q [$];
    logic       exp_valid = 1'b0;
    logic       exp_error = 1'b0;

    mc8123_key_loader #(
        .KEY_INDEX(KEY_INDEX),
        .KEY_BASE (KEY_BASE),
        .KEY_BYTES(KEY_BYTES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .key_a         (key_a),
        .key_d         (key_d),
        .key_valid     (key_valid),
        .load_error    (load_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an address, expect the given byte one cycle later.
    task automatic read_check(input string name, input logic [12:0] addr, input logic [7:0] exp);
        logic [7:0] e;
        key_a = addr;
        exp_q.push_back(exp);
        tick();
        e = exp_q.pop_front();
        total++;
        if (key_d !== e) $display("FAIL %s: key_d=%h expected %h", name, key_d, e);
        else passed++;
    endtask

    task automatic check_flags(input string name);
        total++;
        if ({key_valid, load_error, busy} !== {exp_valid, exp_error, 1'b0})
            $display("FAIL %s: valid/error/busy=%b%b%b expected %b%b0", name,
                     key_valid, load_error, busy, exp_valid, exp_error);
        else passed++;
    endtask

    // Generic download: n writes starting at start (wrapping by key size), data = offset^mask.
    // A non-negative reset_at pulses reset just before that byte and abandons the download.
    task automatic download(input string name, input logic [7:0] idx, input logic [24:0] start,
                            input int n, input logic [7:0] mask, input int reset_at);
        logic [24:0] a;
        logic [12:0] off;
        int          in_cnt;
        logic        busy_seen_low;
        logic        is_key;
        is_key = (idx == KEY_INDEX);
        in_cnt = 0;
        busy_seen_low = 1'b0;
        ioctl_index = idx;
        ioctl_download = 1'b1;
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            if (i == reset_at) begin
                reset = 1'b1;
                #1;
                total++;
                if ({busy, key_valid, load_error} !== 3'b000)
                    $display("FAIL %s reset: busy/valid/error=%b%b%b expected 000", name,
                             busy, key_valid, load_error);
                else passed++;
                ioctl_wr = 1'b0;
                ioctl_download = 1'b0;
                tick();
                reset = 1'b0;
                tick();
                exp_valid = 1'b0;
                exp_error = 1'b0;
                return;
            end
            a = start + 25'(i % KEY_BYTES);
            off = a[12:0] - KEY_BASE[12:0];
            ioctl_wr = 1'b1;
            ioctl_addr = a;
            ioctl_dout = off[7:0] ^ mask;
            if (busy !== is_key) busy_seen_low = 1'b1;
            if (is_key && a >= KEY_BASE && a < KEY_BASE + 25'(KEY_BYTES)) begin
                model[off] = off[7:0] ^ mask;
                in_cnt++;
            end
            tick();
        end
        ioctl_wr = 1'b0;
        total++;
        if (busy_seen_low || busy !== is_key)
            $display("FAIL %s busy: busy=%b expected %b throughout", name, busy, is_key);
        else passed++;
        ioctl_download = 1'b0;
        tick();
        tick();
        if (is_key) begin
            exp_valid = (in_cnt == KEY_BYTES);
            exp_error = (in_cnt != 0) && (in_cnt != KEY_BYTES);
        end
        check_flags(name);
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({key_d, key_valid, load_error, busy} !== 11'd0)
            $display("FAIL reset: key_d=%h valid=%b error=%b busy=%b expected all 0",
                     key_d, key_valid, load_error, busy);
        else passed++;
        tick();
        reset = 1'b0;
        tick();
        check_flags("idle_after_reset");
    endtask

    task automatic test_full_load();
        download("full_load", KEY_INDEX, KEY_BASE, KEY_BYTES, 8'h5A, -1);
        read_check("key_1234", 13'h1234, 8'h6E);
        read_check("key_0000", 13'h0000, 8'h5A);
        read_check("key_1fff", 13'h1FFF, 8'hA5);
    endtask

    task automatic test_other_index();
        download("other_index", KEY_INDEX + 8'd1, KEY_BASE, 1000, 8'hFF, -1);
        read_check("other_idx_ram", 13'h0003, model[3]);
    endtask

    task automatic test_partial();
        download("short_8000", KEY_INDEX, KEY_BASE, 8000, 8'h33, -1);
        read_check("short_ram", 13'h0100, model[13'h0100]);
        download("long_8193", KEY_INDEX, KEY_BASE, KEY_BYTES + 1, 8'h5A, -1);
    endtask

    task automatic test_out_of_window();
        download("below_base", KEY_INDEX, KEY_BASE - 25'd1000, 1000, 8'h11, -1);
        read_check("below_base_ram", 13'h0000, model[0]);
    endtask

    task automatic test_reset_mid_load();
        download("reset_mid", KEY_INDEX, KEY_BASE, KEY_BYTES, 8'h77, 4000);
        check_flags("after_reset_mid");
        read_check("reset_mid_ram", 13'h0005, model[5]);
        download("reload", KEY_INDEX, KEY_BASE, KEY_BYTES, 8'h5A, -1);
        read_check("reload_1234", 13'h1234, 8'h6E);
    endtask

    task automatic test_read_first();
        logic [7:0] e;
        ioctl_index = KEY_INDEX;
        ioctl_download = 1'b1;
        tick();
        tick();
        ioctl_wr = 1'b1;
        ioctl_addr = KEY_BASE + 25'h10;
        ioctl_dout = 8'h3C;
        tick();
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        tick();
        tick();
        exp_valid = 1'b0;
        exp_error = 1'b1;
        check_flags("single_byte");
        read_check("preload_3c", 13'h0010, 8'h3C);

        ioctl_download = 1'b1;
        tick();
        tick();
        key_a = 13'h0010;
        ioctl_wr = 1'b1;
        ioctl_dout = 8'hA5;
        exp_q.push_back(8'h3C);
        tick();
        ioctl_wr = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (key_d !== e) $display("FAIL read_first_old: key_d=%h expected %h", key_d, e);
        else passed++;
        exp_q.push_back(8'hA5);
        tick();
        e = exp_q.pop_front();
        total++;
        if (key_d !== e) $display("FAIL read_first_new: key_d=%h expected %h", key_d, e);
        else passed++;
        ioctl_download = 1'b0;
        tick();
        tick();
        check_flags("read_first_flags");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_other_index();
        test_partial();
        test_out_of_window();
        test_reset_mid_load();
        test_read_first();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
